// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared types and widths for the capture write sequencer
// Contents: FSM state enum, address/data/index/drop-count widths and a
// saturating increment helper for the drop counter.
package capture_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 8;
  localparam int IDX_W   = 8;
  localparam int COUNT_W = 32;
  localparam int DROP_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_STREAM,
    ST_WAIT_DONE
  } cap_state_t;

  // Counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/capture_write_sequencer_if.sv
// rtl/capture_write_sequencer_if.sv - write-master control and user FIFO port bundle
// Signals:
//   ctl_fixed_location, ctl_write_base, ctl_write_length, ctl_go : sequencer -> write master
//   ctl_done                                                     : write master -> sequencer
//   usr_write_buffer, usr_buffer_input_data                      : sequencer -> write master FIFO
//   usr_buffer_full                                              : write master FIFO -> sequencer
// Modports: master (sequencer side), slave (write master side).
interface capture_write_sequencer_if;
  import capture_pkg::*;

  logic              ctl_fixed_location;
  logic [ADDR_W-1:0] ctl_write_base;
  logic [ADDR_W-1:0] ctl_write_length;
  logic              ctl_go;
  logic              ctl_done;
  logic              usr_write_buffer;
  logic [DATA_W-1:0] usr_buffer_input_data;
  logic              usr_buffer_full;

  modport master (
    output ctl_fixed_location, ctl_write_base, ctl_write_length, ctl_go,
    output usr_write_buffer, usr_buffer_input_data,
    input  ctl_done, usr_buffer_full
  );

  modport slave (
    input  ctl_fixed_location, ctl_write_base, ctl_write_length, ctl_go,
    input  usr_write_buffer, usr_buffer_input_data,
    output ctl_done, usr_buffer_full
  );

endinterface

// File: rtl/capture_addr_gen.sv
// rtl/capture_addr_gen.sv - ring block index and SDRAM base address generation
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   clear_index  : restart the ring at block 0
//   advance      : step to the next block, wrapping NUM_BLOCKS-1 -> 0
//   load_base    : capture the base address of the index in effect next cycle
//   blk_index    : current block index
//   write_base   : registered SDRAM byte address of the loaded block
module capture_addr_gen
  import capture_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                BLOCK_BYTES = 1024,
  parameter int                NUM_BLOCKS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_index,
  input  logic              advance,
  input  logic              load_base,
  output logic [IDX_W-1:0]  blk_index,
  output logic [ADDR_W-1:0] write_base
);

  localparam int               SHIFT    = $clog2(BLOCK_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

  logic [IDX_W-1:0]  idx_n;
  logic [ADDR_W-1:0] base_n;

  // The base is computed from the next index so that a clear or advance in
  // the same cycle as the load is already reflected in the START address.
  always_comb begin
    idx_n = blk_index;
    if (clear_index) begin
      idx_n = '0;
    end else if (advance) begin
      idx_n = (blk_index == LAST_IDX) ? '0 : blk_index + 1'b1;
    end
    // BLOCK_BYTES is a power of two, so the multiply is a shift; the add wraps at 32 bits.
    base_n = BASE_ADDR + (ADDR_W'(idx_n) << SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_index  <= '0;
      write_base <= BASE_ADDR;
    end else begin
      blk_index <= idx_n;
      if (load_base) begin
        write_base <= base_n;
      end
    end
  end

endmodule

// File: rtl/capture_write_sequencer.sv
// rtl/capture_write_sequencer.sv - streams source bytes into a ring of SDRAM blocks via a write master
// Ports:
//   clk_clk, reset_reset : sole clock, asynchronous active-high reset
//   arm                  : capture enable level
//   src_valid, src_data  : unstallable byte source
//   wm                   : write-master control + user FIFO port (master modport)
//   busy                 : high in every state except IDLE
//   block_done           : one-cycle pulse after each completed block
//   blk_index            : ring index of the current/next block
//   blk_count            : completed blocks, wraps modulo 2^32
//   drop_count           : source bytes not accepted, saturating
module capture_write_sequencer
  import capture_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                BLOCK_BYTES = 1024,
  parameter int                NUM_BLOCKS  = 8
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  input  logic                       arm,
  input  logic                       src_valid,
  input  logic [DATA_W-1:0]          src_data,
  capture_write_sequencer_if.master  wm,
  output logic                       busy,
  output logic                       block_done,
  output logic [IDX_W-1:0]           blk_index,
  output logic [COUNT_W-1:0]         blk_count,
  output logic [DROP_W-1:0]          drop_count
);

  localparam int               CNT_W     = $clog2(BLOCK_BYTES) + 1;
  localparam logic [CNT_W-1:0] BLK_BYTES = CNT_W'(BLOCK_BYTES);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BLOCK_BYTES - 1);

  cap_state_t       state, state_n;
  logic             arm_q;
  logic             wd_armed;
  logic [CNT_W-1:0] byte_cnt;

  logic accept;
  logic last_byte;
  logic arm_rise;
  logic wd_exit;
  logic load_base;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    wm.ctl_go = 1'b0;
    busy      = (state != ST_IDLE);
    accept    = (state == ST_STREAM) && src_valid && !wm.usr_buffer_full &&
                (byte_cnt < BLK_BYTES);
    last_byte = accept && (byte_cnt == LAST_BYTE);
    arm_rise  = (state == ST_IDLE) && arm && !arm_q;
    // The first WAIT_DONE cycle is skipped so a done still high from the
    // previous transfer cannot close the block early.
    wd_exit   = (state == ST_WAIT_DONE) && wd_armed && wm.ctl_done;

    unique case (state)
      ST_IDLE: begin
        if (arm && wm.ctl_done) state_n = ST_START;
      end
      ST_START: begin
        wm.ctl_go = 1'b1;
        state_n   = ST_STREAM;
      end
      ST_STREAM: begin
        // arm is deliberately not looked at here: a started block always completes.
        if (last_byte) state_n = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (wd_exit) state_n = arm ? ST_START : ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    load_base = (state_n == ST_START) && (state != ST_START);
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      arm_q      <= 1'b0;
      wd_armed   <= 1'b0;
      byte_cnt   <= '0;
      drop_count <= '0;
      blk_count  <= '0;
      block_done <= 1'b0;
    end else begin
      arm_q      <= arm;
      wd_armed   <= (state == ST_WAIT_DONE);
      block_done <= wd_exit;
      if (state == ST_START) begin
        byte_cnt <= '0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 1'b1;
      end
      if (src_valid && !accept) begin
        drop_count <= sat_inc(drop_count);
      end
      if (wd_exit) begin
        blk_count <= blk_count + 1'b1;
      end
    end
  end

  capture_addr_gen #(
    .BASE_ADDR   (BASE_ADDR),
    .BLOCK_BYTES (BLOCK_BYTES),
    .NUM_BLOCKS  (NUM_BLOCKS)
  ) u_addr_gen (
    .clk         (clk_clk),
    .rst         (reset_reset),
    .clear_index (arm_rise),
    .advance     (wd_exit),
    .load_base   (load_base),
    .blk_index   (blk_index),
    .write_base  (wm.ctl_write_base)
  );

  assign wm.ctl_fixed_location    = 1'b0;
  assign wm.ctl_write_length      = ADDR_W'(BLOCK_BYTES);
  assign wm.usr_write_buffer      = accept;
  assign wm.usr_buffer_input_data = src_data;

endmodule

// File: tb/tb_capture_write_sequencer.sv
// tb/tb_capture_write_sequencer.sv - scoreboard bench for capture_write_sequencer
module tb_capture_write_sequencer;
  import capture_pkg::*;

  localparam int          BB   = 16;
  localparam int          NB   = 2;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              arm;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              busy;
  logic              block_done;
  logic [IDX_W-1:0]  blk_index;
  logic [31:0]       blk_count;
  logic [15:0]       drop_count;

  capture_write_sequencer_if wm();

  capture_write_sequencer #(
    .BASE_ADDR   (BASE),
    .BLOCK_BYTES (BB),
    .NUM_BLOCKS  (NB)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .arm         (arm),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .wm          (wm),
    .busy        (busy),
    .block_done  (block_done),
    .blk_index   (blk_index),
    .blk_count   (blk_count),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cnt;
    logic [7:0]  idx;
  } done_exp_t;

  logic [31:0] go_q[$];
  logic [7:0]  wr_q[$];
  done_exp_t   done_q[$];

  int          tests = 0;
  int          fails = 0;
  bit          strict = 1'b0;
  int          done_delay = 1;
  int          exp_drops = 0;
  logic [7:0]  data_seq = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  function automatic done_exp_t mk_done(input logic [31:0] c, input logic [7:0] i);
    done_exp_t e;
    e.cnt = c;
    e.idx = i;
    return e;
  endfunction

  // Monitor: pops expectations whenever the DUT presents go, a write or block_done.
  initial begin
    int        go_seen;
    int        done_seen;
    int        blk_wr;
    done_exp_t e;
    go_seen = 0;
    done_seen = 0;
    blk_wr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        go_seen = 0;
        done_seen = 0;
        blk_wr = 0;
      end else begin
        if (block_done) begin
          if (done_q.size() == 0) begin
            fail_event("unexpected_block_done");
          end else begin
            e = done_q.pop_front();
            check("done_blk_count", blk_count, e.cnt);
            check("done_blk_index", 32'(blk_index), 32'(e.idx));
            check("writes_per_block", blk_wr, BB);
          end
          done_seen++;
        end
        if (wm.ctl_go) begin
          if (go_q.size() == 0) begin
            fail_event("unexpected_go");
          end else begin
            check("go_base", wm.ctl_write_base, go_q.pop_front());
          end
          check("go_length", wm.ctl_write_length, BB);
          check("go_after_prev_done", done_seen, go_seen);
          go_seen++;
          blk_wr = 0;
        end
        if (wm.usr_write_buffer) begin
          blk_wr++;
          check("wr_passthru", 32'(wm.usr_buffer_input_data), 32'(src_data));
          if (strict) begin
            if (wr_q.size() == 0) fail_event("unexpected_write");
            else check("wr_data", 32'(wm.usr_buffer_input_data), 32'(wr_q.pop_front()));
          end
        end
      end
    end
  end

  // Write-master model: drops done on go, raises it done_delay cycles after the last byte.
  initial begin
    bit go_s;
    bit wr_s;
    bit rst_s;
    bit waiting;
    int cnt;
    int hold;
    waiting = 1'b0;
    cnt = 0;
    hold = 0;
    wm.ctl_done = 1'b1;
    forever begin
      @(negedge clk);
      go_s  = wm.ctl_go;
      wr_s  = wm.usr_write_buffer;
      rst_s = rst;
      @(posedge clk);
      #1;
      if (rst_s || rst) begin
        waiting = 1'b0;
        wm.ctl_done = 1'b1;
      end else if (go_s) begin
        waiting = 1'b1;
        cnt = 0;
        hold = 0;
        wm.ctl_done = 1'b0;
      end else if (waiting) begin
        if (wr_s) cnt++;
        if (cnt >= BB) begin
          hold++;
          if (hold >= done_delay) begin
            wm.ctl_done = 1'b1;
            waiting = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_go(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wm.ctl_go) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL go_timeout: no ctl_go within 300 cycles, expected one");
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", ok, 1'b1);
  endtask

  // Drives one block from its go pulse: valid every STREAM cycle, FIFO full
  // for [full_at, full_at+full_len), optional valid tail into WAIT_DONE.
  task automatic stream_block(input int full_at, input int full_len, input int tail,
                              input int arm_drop_at, input int dly);
    bit ok;
    int n;
    int k;
    wait_go(ok);
    if (!ok) return;
    done_delay = dly;
    @(posedge clk);
    #1;
    n = 0;
    k = 0;
    while (n < BB && k < 200) begin
      src_valid = 1'b1;
      src_data  = data_seq;
      data_seq++;
      wm.usr_buffer_full = (k >= full_at) && (k < full_at + full_len);
      if (!wm.usr_buffer_full) begin
        wr_q.push_back(src_data);
        n++;
        if (n == arm_drop_at) arm = 1'b0;
      end else begin
        exp_drops++;
      end
      k++;
      @(posedge clk);
      #1;
    end
    wm.usr_buffer_full = 1'b0;
    repeat (tail) begin
      src_valid = 1'b1;
      src_data  = data_seq;
      data_seq++;
      exp_drops++;
      @(posedge clk);
      #1;
    end
    src_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},       busy, 1'b0);
    check({tag, "_go"},         wm.ctl_go, 1'b0);
    check({tag, "_wr"},         wm.usr_write_buffer, 1'b0);
    check({tag, "_block_done"}, block_done, 1'b0);
    check({tag, "_blk_index"},  32'(blk_index), 32'd0);
    check({tag, "_blk_count"},  blk_count, 32'd0);
    check({tag, "_drop_count"}, 32'(drop_count), 32'd0);
    check({tag, "_base"},       wm.ctl_write_base, BASE);
    check({tag, "_length"},     wm.ctl_write_length, BB);
    check({tag, "_fixed"},      wm.ctl_fixed_location, 1'b0);
  endtask

  initial begin
    bit ok;
    int gos;
    int cyc;
    rst = 1'b1;
    arm = 1'b0;
    src_valid = 1'b0;
    src_data = 8'h00;
    wm.usr_buffer_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    src_valid = 1'b1;
    #1;
    check_reset_outputs("reset");
    src_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Test 1: continuous source, three blocks around the two-block ring.
    strict = 1'b0;
    go_q.push_back(32'h0);
    go_q.push_back(32'h10);
    go_q.push_back(32'h0);
    done_q.push_back(mk_done(32'd1, 8'd1));
    done_q.push_back(mk_done(32'd2, 8'd0));
    done_q.push_back(mk_done(32'd3, 8'd1));
    arm = 1'b1;
    gos = 0;
    ok = 1'b0;
    for (cyc = 0; cyc < 1000; cyc++) begin
      @(posedge clk);
      #1;
      src_valid = 1'b1;
      src_data  = data_seq;
      data_seq++;
      if (gos == 3) arm = 1'b0;
      @(negedge clk);
      if (wm.ctl_go) gos++;
      if (gos == 3 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("t1_completed", ok, 1'b1);
    @(posedge clk);
    #1;
    src_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t1_go_q_empty", go_q.size(), 0);
    check("t1_done_q_empty", done_q.size(), 0);
    check("t1_blk_count", blk_count, 32'd3);

    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_drops = 0;

    // Tests 2, 4, 3: full gap, long WAIT_DONE with valid tail, arm dropped early.
    strict = 1'b1;
    go_q.push_back(32'h0);
    go_q.push_back(32'h10);
    go_q.push_back(32'h0);
    done_q.push_back(mk_done(32'd1, 8'd1));
    done_q.push_back(mk_done(32'd2, 8'd0));
    done_q.push_back(mk_done(32'd3, 8'd1));
    arm = 1'b1;
    stream_block(5, 5, 0, 0, 1);
    @(negedge clk);
    check("t2_drop_count", 32'(drop_count), 32'd5);
    stream_block(100, 0, 10, 0, 21);
    @(negedge clk);
    check("t4_drop_count", 32'(drop_count), 32'd15);
    check("t4_busy_in_wait", busy, 1'b1);
    check("t4_no_go_in_wait", wm.ctl_go, 1'b0);
    check("t4_done_held_low", wm.ctl_done, 1'b0);
    stream_block(100, 0, 0, 3, 1);
    wait_idle(100);
    repeat (3) @(negedge clk);
    check("t3_busy_low", busy, 1'b0);
    check("t3_arm_low", arm, 1'b0);
    check("t3_blk_count", blk_count, 32'd3);
    check("t3_drop_count", 32'(drop_count), exp_drops);
    check("t3_go_q_empty", go_q.size(), 0);
    check("t3_wr_q_empty", wr_q.size(), 0);
    check("t3_done_q_empty", done_q.size(), 0);

    // Test 5: one full block, then async reset part-way through the next one.
    go_q.push_back(32'h0);
    go_q.push_back(32'h10);
    done_q.push_back(mk_done(32'd4, 8'd1));
    @(posedge clk);
    #1;
    arm = 1'b1;
    stream_block(100, 0, 0, 0, 1);
    wait_go(ok);
    @(posedge clk);
    #1;
    repeat (5) begin
      src_valid = 1'b1;
      src_data  = data_seq;
      data_seq++;
      wr_q.push_back(src_data);
      @(posedge clk);
      #1;
    end
    check("t5_pre_reset_index", 32'(blk_index), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("t5_async");
    src_valid = 1'b0;
    check("t5_wr_q_empty", wr_q.size(), 0);
    go_q.push_back(BASE);
    done_q.push_back(mk_done(32'd1, 8'd1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_drops = 0;
    stream_block(100, 0, 0, 3, 1);
    wait_idle(100);
    repeat (3) @(negedge clk);
    check("t5_blk_count", blk_count, 32'd1);
    check("t5_blk_index", 32'(blk_index), 32'd1);
    check("t5_go_q_empty", go_q.size(), 0);
    check("t5_done_q_empty", done_q.size(), 0);
    check("t5_drop_count", 32'(drop_count), 32'd0);

    // Test 6: drop-counter saturation while idle.
    @(posedge clk);
    #1;
    src_valid = 1'b1;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    check("t6_drop_fffe", 32'(drop_count), 32'h0000_FFFE);
    repeat (70000 - 65534) @(posedge clk);
    @(negedge clk);
    check("t6_drop_sat", 32'(drop_count), 32'h0000_FFFF);
    check("t6_idle", busy, 1'b0);
    src_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
